// File: rtl/comparador_pkg.sv
// ----------------------------------------------------------------------------
// comparador_pkg
// Shared constants and types for the programmable set-membership comparator.
//   ANCHO_DEF       : default width of stored values and query input.
//   PROFUNDIDAD_DEF : default number of table entries.
//   entrada_t       : one table entry {valido, dato} at the default width.
// ----------------------------------------------------------------------------
package comparador_pkg;

    localparam int ANCHO_DEF       = 6;
    localparam int PROFUNDIDAD_DEF = 32;

    typedef struct packed {
        logic                 valido;
        logic [ANCHO_DEF-1:0] dato;
    } entrada_t;

endpackage : comparador_pkg

// File: rtl/comparador_conjunto_programable_if.sv
// ----------------------------------------------------------------------------
// comparador_conjunto_programable_if
// Groups the write, clear and query signals of the comparator.
//   master : drives Escribir/DirEscritura/DatoEscritura/BitValido,
//            BorrarTodo, ConsultaValida/Entrada; observes the results.
//   slave  : the comparator; drives Salida, SalidaValida, Indice, Ocupados.
// ----------------------------------------------------------------------------
interface comparador_conjunto_programable_if
    import comparador_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
);
    localparam int ANCHO_IDX = $clog2(PROFUNDIDAD);

    logic                 Escribir;
    logic [ANCHO_IDX-1:0] DirEscritura;
    logic [ANCHO-1:0]     DatoEscritura;
    logic                 BitValido;
    logic                 BorrarTodo;
    logic                 ConsultaValida;
    logic [ANCHO-1:0]     Entrada;
    logic                 Salida;
    logic                 SalidaValida;
    logic [ANCHO_IDX-1:0] Indice;
    logic [ANCHO_IDX:0]   Ocupados;

    modport master (
        output Escribir, DirEscritura, DatoEscritura, BitValido,
        output BorrarTodo, ConsultaValida, Entrada,
        input  Salida, SalidaValida, Indice, Ocupados
    );

    modport slave (
        input  Escribir, DirEscritura, DatoEscritura, BitValido,
        input  BorrarTodo, ConsultaValida, Entrada,
        output Salida, SalidaValida, Indice, Ocupados
    );

endinterface : comparador_conjunto_programable_if

// File: rtl/codificador_prioridad.sv
// ----------------------------------------------------------------------------
// codificador_prioridad
// Combinational lowest-index priority encoder.
//   coincidencias_i : request/match vector, bit 0 has highest priority.
//   indice_o        : index of the lowest set bit (0 when none set).
//   alguno_o        : 1 when any bit is set.
// ----------------------------------------------------------------------------
module codificador_prioridad #(
    parameter  int N = 32,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] coincidencias_i,
    output logic [W-1:0] indice_o,
    output logic         alguno_o
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        indice_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (coincidencias_i[i]) begin
                indice_o = W'(i);
            end
        end
    end

    assign alguno_o = |coincidencias_i;

endmodule : codificador_prioridad

// File: rtl/comparador_conjunto_programable.sv
// ----------------------------------------------------------------------------
// comparador_conjunto_programable
// Programmable set-membership comparator with a run-time loaded table.
//   Reloj   : clock, all state on the rising edge.
//   Reset_n : asynchronous active-low reset (clears valid bits and outputs).
//   bus     : slave modport carrying write port (Escribir, DirEscritura,
//             DatoEscritura, BitValido), bulk clear (BorrarTodo), query
//             (ConsultaValida, Entrada) and results (Salida, SalidaValida,
//             Indice, Ocupados).
// A query compares Entrada against every valid entry in parallel using the
// table state before the edge; the result is registered one cycle later.
// ----------------------------------------------------------------------------
module comparador_conjunto_programable
    import comparador_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
    input  logic                                Reloj,
    input  logic                                Reset_n,
    comparador_conjunto_programable_if.slave    bus
);

    localparam int ANCHO_IDX = $clog2(PROFUNDIDAD);
    localparam int ANCHO_OCU = ANCHO_IDX + 1;

    logic [PROFUNDIDAD-1:0] valido_q, valido_d;
    logic [ANCHO-1:0]       dato_q [PROFUNDIDAD];
    logic [PROFUNDIDAD-1:0] sel_escritura;
    logic [PROFUNDIDAD-1:0] coincidencias;
    logic                   escritura_activa;
    logic                   valido_previo;
    logic [ANCHO_OCU-1:0]   ocupados_q, ocupados_d;
    logic                   salida_q, salida_d;
    logic                   salida_valida_q;
    logic [ANCHO_IDX-1:0]   indice_q, indice_d;
    logic                   alguno;
    logic [ANCHO_IDX-1:0]   indice_cod;

    // Per-entry decode. An out-of-range address matches no entry, so such a
    // write simply has no effect. A same-cycle clear suppresses the write.
    generate
        for (genvar gi = 0; gi < PROFUNDIDAD; gi++) begin : g_entrada
            assign sel_escritura[gi] = bus.Escribir && !bus.BorrarTodo &&
                                       (bus.DirEscritura == ANCHO_IDX'(gi));
            assign valido_d[gi]      = bus.BorrarTodo  ? 1'b0 :
                                       sel_escritura[gi] ? bus.BitValido :
                                       valido_q[gi];
            assign coincidencias[gi] = valido_q[gi] && (dato_q[gi] == bus.Entrada);
        end
    endgenerate

    assign escritura_activa = |sel_escritura;
    assign valido_previo    = |(sel_escritura & valido_q);

    // Data needs no reset: it is only observed through its valid bit.
    always_ff @(posedge Reloj) begin
        for (int i = 0; i < PROFUNDIDAD; i++) begin
            if (sel_escritura[i]) begin
                dato_q[i] <= bus.DatoEscritura;
            end
        end
    end

    codificador_prioridad #(.N(PROFUNDIDAD)) u_codificador (
        .coincidencias_i (coincidencias),
        .indice_o        (indice_cod),
        .alguno_o        (alguno)
    );

    // Occupancy tracks only the valid-bit transition of the single written
    // entry, which keeps it equal to the population count of valido_q.
    always_comb begin
        ocupados_d = ocupados_q;
        if (bus.BorrarTodo) begin
            ocupados_d = '0;
        end else if (escritura_activa && bus.BitValido && !valido_previo) begin
            ocupados_d = ocupados_q + ANCHO_OCU'(1);
        end else if (escritura_activa && !bus.BitValido && valido_previo) begin
            ocupados_d = ocupados_q - ANCHO_OCU'(1);
        end
    end

    // Results hold between queries.
    always_comb begin
        salida_d = salida_q;
        indice_d = indice_q;
        if (bus.ConsultaValida) begin
            salida_d = alguno;
            indice_d = indice_cod;
        end
    end

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            valido_q        <= '0;
            ocupados_q      <= '0;
            salida_q        <= 1'b0;
            salida_valida_q <= 1'b0;
            indice_q        <= '0;
        end else begin
            valido_q        <= valido_d;
            ocupados_q      <= ocupados_d;
            salida_q        <= salida_d;
            salida_valida_q <= bus.ConsultaValida;
            indice_q        <= indice_d;
        end
    end

    assign bus.Salida       = salida_q;
    assign bus.SalidaValida = salida_valida_q;
    assign bus.Indice       = indice_q;
    assign bus.Ocupados     = ocupados_q;

endmodule : comparador_conjunto_programable

// File: tb/tb_comparador_conjunto_programable.sv
module tb_comparador_conjunto_programable;

    logic Reloj;
    logic Reset_n;

    comparador_conjunto_programable_if #(.ANCHO(6), .PROFUNDIDAD(32)) bus_a ();
    comparador_conjunto_programable_if #(.ANCHO(6), .PROFUNDIDAD(20)) bus_b ();

    comparador_conjunto_programable #(.ANCHO(6), .PROFUNDIDAD(32)) dut_a (
        .Reloj   (Reloj),
        .Reset_n (Reset_n),
        .bus     (bus_a)
    );

    comparador_conjunto_programable #(.ANCHO(6), .PROFUNDIDAD(20)) dut_b (
        .Reloj   (Reloj),
        .Reset_n (Reset_n),
        .bus     (bus_b)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    typedef struct {
        logic salida;
        int   indice;
    } esperado_t;

    esperado_t cola[$];

    int checks   = 0;
    int failures = 0;

    // Reference model of the table (state before the next edge).
    bit [31:0] m_valido;
    int        m_dato [32];

    int legado [22] = '{1, 2, 3, 5, 10, 12, 13, 15, 20, 21, 22,
                        23, 25, 30, 31, 32, 33, 35, 50, 51, 52, 53};

    task automatic comprobar(input string tag, input logic [31:0] obtenido,
                             input logic [31:0] esperado);
        checks++;
        if (obtenido !== esperado) begin
            failures++;
            $display("FAIL %s obtenido=%0d esperado=%0d t=%0t", tag, obtenido, esperado, $time);
        end
    endtask

    // One clock cycle on DUT A: drive, predict, clock, check.
    task automatic op(input logic esc, input int dir, input int dato, input logic bv,
                      input logic borrar, input logic cons, input int ent);
        esperado_t e;
        bus_a.Escribir       = esc;
        bus_a.DirEscritura   = 5'(dir);
        bus_a.DatoEscritura  = 6'(dato);
        bus_a.BitValido      = bv;
        bus_a.BorrarTodo     = borrar;
        bus_a.ConsultaValida = cons;
        bus_a.Entrada        = 6'(ent);
        if (cons) begin
            e.salida = 1'b0;
            e.indice = 0;
            for (int i = 31; i >= 0; i--) begin
                if (m_valido[i] && m_dato[i] == ent) begin
                    e.salida = 1'b1;
                    e.indice = i;
                end
            end
            cola.push_back(e);
        end
        if (borrar) begin
            m_valido = '0;
        end else if (esc && dir < 32) begin
            m_valido[dir] = bv;
            m_dato[dir]   = dato;
        end
        @(posedge Reloj);
        #1;
        comprobar("valida", 32'(bus_a.SalidaValida), 32'(cons));
        if (cola.size() > 0) begin
            e = cola.pop_front();
            if (bus_a.SalidaValida) begin
                comprobar($sformatf("salida[%0d]", ent), 32'(bus_a.Salida), 32'(e.salida));
                comprobar($sformatf("indice[%0d]", ent), 32'(bus_a.Indice), 32'(e.indice));
            end
        end
        comprobar("ocupados", 32'(bus_a.Ocupados), 32'($countones(m_valido)));
        $display("op esc=%0b dir=%0d dato=%0d bv=%0b clr=%0b q=%0b ent=%0d -> v=%0b s=%0b i=%0d ocu=%0d",
                 esc, dir, dato, bv, borrar, cons, ent, bus_a.SalidaValida,
                 bus_a.Salida, bus_a.Indice, bus_a.Ocupados);
    endtask

    task automatic op_b(input logic esc, input int dir, input int dato, input logic cons,
                        input int ent);
        bus_b.Escribir       = esc;
        bus_b.DirEscritura   = 5'(dir);
        bus_b.DatoEscritura  = 6'(dato);
        bus_b.BitValido      = 1'b1;
        bus_b.BorrarTodo     = 1'b0;
        bus_b.ConsultaValida = cons;
        bus_b.Entrada        = 6'(ent);
        @(posedge Reloj);
        #1;
        $display("op_b esc=%0b dir=%0d dato=%0d q=%0b ent=%0d -> v=%0b s=%0b i=%0d ocu=%0d",
                 esc, dir, dato, cons, ent, bus_b.SalidaValida, bus_b.Salida,
                 bus_b.Indice, bus_b.Ocupados);
    endtask

    initial begin
        m_valido = '0;
        foreach (m_dato[i]) m_dato[i] = 0;
        Reset_n = 1'b0;
        bus_a.Escribir = 0; bus_a.DirEscritura = '0; bus_a.DatoEscritura = '0;
        bus_a.BitValido = 0; bus_a.BorrarTodo = 0; bus_a.ConsultaValida = 1;
        bus_a.Entrada = '0;
        bus_b.Escribir = 0; bus_b.DirEscritura = '0; bus_b.DatoEscritura = '0;
        bus_b.BitValido = 0; bus_b.BorrarTodo = 0; bus_b.ConsultaValida = 0;
        bus_b.Entrada = '0;

        // Reset held while querying 0.
        repeat (3) @(posedge Reloj);
        #1;
        comprobar("rst_salida", 32'(bus_a.Salida), 0);
        comprobar("rst_valida", 32'(bus_a.SalidaValida), 0);
        comprobar("rst_indice", 32'(bus_a.Indice), 0);
        comprobar("rst_ocupados", 32'(bus_a.Ocupados), 0);
        Reset_n = 1'b1;
        bus_a.ConsultaValida = 0;

        op(0, 0, 0, 0, 0, 1, 0);
        comprobar("post_rst_valida", 32'(bus_a.SalidaValida), 1);
        comprobar("post_rst_salida", 32'(bus_a.Salida), 0);

        // Load the legacy set into entries 0..21.
        for (int i = 0; i < 22; i++) op(1, i, legado[i], 1, 0, 0, 0);
        comprobar("ocupados_22", 32'(bus_a.Ocupados), 22);

        // Sweep every input value back to back.
        for (int v = 0; v < 64; v++) op(0, 0, 0, 0, 0, 1, v);

        op(0, 0, 0, 0, 0, 1, 12);
        comprobar("idx_12", 32'(bus_a.Indice), 5);
        op(0, 0, 0, 0, 0, 1, 53);
        comprobar("idx_53", 32'(bus_a.Indice), 21);
        op(0, 0, 0, 0, 0, 1, 4);
        comprobar("sal_4", 32'(bus_a.Salida), 0);
        comprobar("idx_4", 32'(bus_a.Indice), 0);

        // Same-cycle write and query: write not yet visible.
        op(1, 22, 7, 1, 0, 1, 7);
        comprobar("wq_misma", 32'(bus_a.Salida), 0);
        op(0, 0, 0, 0, 0, 1, 7);
        comprobar("wq_sig_sal", 32'(bus_a.Salida), 1);
        comprobar("wq_sig_idx", 32'(bus_a.Indice), 22);
        comprobar("wq_ocup", 32'(bus_a.Ocupados), 23);

        // Rewrite of a valid entry keeps the count.
        op(1, 10, 20, 1, 0, 0, 0);
        comprobar("reescr_ocup", 32'(bus_a.Ocupados), 23);

        // Duplicates and invalidation.
        op(1, 30, 5, 1, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 5);
        comprobar("dup_idx", 32'(bus_a.Indice), 3);
        op(1, 3, 5, 0, 0, 0, 0);
        comprobar("inval_ocup", 32'(bus_a.Ocupados), 23);
        op(0, 0, 0, 0, 0, 1, 5);
        comprobar("inval_idx", 32'(bus_a.Indice), 30);

        // Clear beats a same-cycle write.
        op(1, 0, 44, 1, 1, 0, 0);
        comprobar("borrar_ocup", 32'(bus_a.Ocupados), 0);
        op(0, 0, 0, 0, 0, 1, 44);
        comprobar("borrar_sal", 32'(bus_a.Salida), 0);

        // Second instance: 20 entries, out-of-range write ignored.
        op(0, 0, 0, 0, 0, 0, 0);
        op_b(1, 3, 9, 0, 0);
        comprobar("b_ocup1", 32'(bus_b.Ocupados), 1);
        op_b(1, 25, 11, 0, 0);
        comprobar("b_fuera_ocup", 32'(bus_b.Ocupados), 1);
        op_b(0, 0, 0, 1, 11);
        comprobar("b_fuera_sal", 32'(bus_b.Salida), 0);
        op_b(0, 0, 0, 1, 9);
        comprobar("b_sal9", 32'(bus_b.Salida), 1);
        comprobar("b_idx9", 32'(bus_b.Indice), 3);
        op_b(1, 19, 11, 0, 0);
        comprobar("b_ocup2", 32'(bus_b.Ocupados), 2);
        op_b(0, 0, 0, 1, 11);
        comprobar("b_idx19", 32'(bus_b.Indice), 19);
        op_b(0, 0, 0, 0, 0);

        // Reset pulse between a query edge and the next edge.
        op(1, 2, 12, 1, 0, 0, 0);
        bus_a.Escribir = 0; bus_a.BorrarTodo = 0;
        bus_a.ConsultaValida = 1; bus_a.Entrada = 6'd12;
        @(posedge Reloj);
        #1;
        comprobar("pre_rst_valida", 32'(bus_a.SalidaValida), 1);
        comprobar("pre_rst_salida", 32'(bus_a.Salida), 1);
        comprobar("pre_rst_idx", 32'(bus_a.Indice), 2);
        bus_a.ConsultaValida = 0;
        #1 Reset_n = 1'b0;
        #1;
        comprobar("mid_rst_salida", 32'(bus_a.Salida), 0);
        comprobar("mid_rst_valida", 32'(bus_a.SalidaValida), 0);
        comprobar("mid_rst_indice", 32'(bus_a.Indice), 0);
        comprobar("mid_rst_ocup", 32'(bus_a.Ocupados), 0);
        comprobar("mid_rst_ocup_b", 32'(bus_b.Ocupados), 0);
        #1 Reset_n = 1'b1;
        m_valido = '0;
        cola.delete();
        @(posedge Reloj);
        #1;
        comprobar("post_pulso_valida", 32'(bus_a.SalidaValida), 0);
        comprobar("post_pulso_salida", 32'(bus_a.Salida), 0);
        $display("reset pulse -> v=%0b s=%0b i=%0d ocu=%0d", bus_a.SalidaValida,
                 bus_a.Salida, bus_a.Indice, bus_a.Ocupados);
        op(0, 0, 0, 0, 0, 1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_comparador_conjunto_programable

// File: doc/comparador_conjunto_programable.md
# comparador_conjunto_programable

Programmable set-membership comparator. Holds up to PROFUNDIDAD values of ANCHO bits in a register table loaded at run time, and answers registered queries with a match flag and the lowest matching entry index. It is the parametrised successor of the fixed 22-element, 6-bit gate-level membership decoder: the set is no longer hard-wired, and the block adds a write port, per-entry valid bits, bulk clear and an occupancy count. It sits between the keypad/input capture logic and the control FSM that consumes Salida.

## Interface
- ANCHO, 6: width of stored values and query input.
- PROFUNDIDAD, 32: number of table entries (≥2; need not be a power of two).
- ANCHO_IDX, $clog2(PROFUNDIDAD): index width (derived; not overridden).
- Reloj  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Escribir  in  1  write strobe for one entry.
- DirEscritura  in  ANCHO_IDX  entry index to write.
- DatoEscritura  in  ANCHO  value stored at DirEscritura.
- BitValido  in  1  valid bit written with the entry (0 = invalidate).
- BorrarTodo  in  1  clears all valid bits.
- ConsultaValida  in  1  query strobe; Entrada sampled this cycle.
- Entrada  in  ANCHO  value to test for membership.
- Salida  out  1  1 if the last query matched a valid entry.
- SalidaValida  out  1  one-cycle pulse: Salida/Indice updated.
- Indice  out  ANCHO_IDX  lowest matching index (0 when Salida=0).
- Ocupados  out  ANCHO_IDX+1  number of valid entries.

## Operation
- Table: PROFUNDIDAD × {valido, dato[ANCHO-1:0]}. Reset clears all valido bits; dato is don't-care (no reset needed).
- Write: Escribir=1 at edge t sets valido[Dir]=BitValido and dato[Dir]=DatoEscritura. Writes with Dir ≥ PROFUNDIDAD are ignored (no state change, Ocupados unchanged).
- BorrarTodo=1 at edge t clears every valido bit. It has priority over a same-cycle Escribir, which is dropped.
- Query: ConsultaValida=1 at edge t compares Entrada against all entries in parallel using table state *before* edge t. The same-cycle write is not visible; it becomes visible from edge t+1.
- Match per entry: valido[i] && dato[i]==Entrada. Salida = OR of all matches. Indice = lowest i with a match, else 0.
- Duplicate values are allowed; the lowest index is reported.
- Salida and Indice hold their value between queries. SalidaValida is high only in the cycle after a query.
- Ocupados is a registered count, updated incrementally: +1 on a 0→1 valido transition, −1 on a 1→0 transition, 0 on a rewrite without change; set to 0 on BorrarTodo. It always equals popcount(valido).
- No handshake back-pressure: a query can be accepted every cycle.

## Timing
- Reset values: Salida=0, SalidaValida=0, Indice=0, Ocupados=0, all valido=0.
- Reset_n assertion mid-operation clears immediately (asynchronous). An in-flight query result is lost; SalidaValida does not pulse after release.
- Query latency: 1 cycle. ConsultaValida at edge t gives Salida/Indice/SalidaValida valid after edge t, usable at edge t+1.
- Write-to-query visibility: 1 cycle. Throughput: one write and one query per cycle, concurrently.
- Ocupados reflects a write or clear from edge t after edge t.
- Critical path: PROFUNDIDAD ANCHO-bit equality compares, then priority encoder, then output register.

## Structure
- Package comparador_pkg: default ANCHO/PROFUNDIDAD constants, and a typedef for the entry struct {valido, dato}.
- Sub-module codificador_prioridad (parameter N): match vector in, lowest-set index plus any-set flag out; combinational. Reused by other lookup blocks.
- Top level holds the table, the write/clear logic, the Ocupados counter and the output registers.

## Test plan
- Reset: hold Reset_n=0, query Entrada=0 → Salida=0, SalidaValida=0, Ocupados=0; after release, query 0 → SalidaValida=1, Salida=0.
- Load the legacy set {1,2,3,5,10,12,13,15,20,21,22,23,25,30,31,32,33,35,50,51,52,53} into entries 0..21 → Ocupados=22. Sweep all 64 Entrada values → Salida=1 exactly for the set members. Query 12 → Indice=5; query 53 → Indice=21; query 4 → Salida=0, Indice=0.
- Same-cycle write+query: write 7 to entry 22 while querying 7 → Salida=0. Query 7 again next cycle → Salida=1, Indice=22, Ocupados=23.
- Duplicates/invalidate: write 5 to entry 30 → query 5 gives Indice=3. Invalidate entry 3 (BitValido=0) → query 5 gives Indice=30, and Ocupados decrements by 1.
- BorrarTodo with Escribir to entry 0 in the same cycle → Ocupados=0, and query of DatoEscritura → Salida=0. With PROFUNDIDAD=20, a write to Dir=25 → no change.
- Reset pulse between a query edge and the next edge → outputs return to reset values and no SalidaValida pulse follows.
